// File: rtl/ctrl_pkg.sv
// Shared types and encodings for the multicycle RV32I control unit:
// FSM states, opcodes, ALU operations and datapath select codes.
package ctrl_pkg;

    typedef enum logic [3:0] {
        FETCH   = 4'd0,
        DECODE  = 4'd1,
        EXECUTE = 4'd2,
        MEM     = 4'd3,
        WB      = 4'd4,
        JUMP    = 4'd5,
        TRAP    = 4'd6
    } state_e;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    typedef enum logic [3:0] {
        ALU_ADD   = 4'd0,
        ALU_SUB   = 4'd1,
        ALU_AND   = 4'd2,
        ALU_OR    = 4'd3,
        ALU_XOR   = 4'd4,
        ALU_SLT   = 4'd5,
        ALU_SLTU  = 4'd6,
        ALU_SLL   = 4'd7,
        ALU_SRL   = 4'd8,
        ALU_SRA   = 4'd9,
        ALU_PASSB = 4'd10
    } alu_op_e;

    localparam logic [1:0] SRC_A_PC    = 2'd0;
    localparam logic [1:0] SRC_A_OLDPC = 2'd1;
    localparam logic [1:0] SRC_A_RS1   = 2'd2;
    localparam logic [1:0] SRC_A_ZERO  = 2'd3;

    localparam logic [1:0] SRC_B_RS2  = 2'd0;
    localparam logic [1:0] SRC_B_IMM  = 2'd1;
    localparam logic [1:0] SRC_B_FOUR = 2'd2;

    localparam logic [2:0] IMM_I = 3'd0;
    localparam logic [2:0] IMM_B = 3'd1;
    localparam logic [2:0] IMM_S = 3'd2;
    localparam logic [2:0] IMM_J = 3'd3;
    localparam logic [2:0] IMM_U = 3'd4;

    localparam logic [1:0] RES_ALUOUT = 2'd0;
    localparam logic [1:0] RES_MEM    = 2'd1;
    localparam logic [1:0] RES_ALU    = 2'd2;

    localparam logic ADR_PC     = 1'b0;
    localparam logic ADR_ALUOUT = 1'b1;
    localparam logic PC_ALU     = 1'b0;
    localparam logic PC_ALUOUT  = 1'b1;

    // Bit 30 selects sub only for register-register adds; shifts use it for sra/srai.
    function automatic alu_op_e alu_decode(logic [2:0] funct3, logic funct7, logic is_r);
        case (funct3)
            3'b000:  return (is_r && funct7) ? ALU_SUB : ALU_ADD;
            3'b001:  return ALU_SLL;
            3'b010:  return ALU_SLT;
            3'b011:  return ALU_SLTU;
            3'b100:  return ALU_XOR;
            3'b101:  return funct7 ? ALU_SRA : ALU_SRL;
            3'b110:  return ALU_OR;
            default: return ALU_AND;
        endcase
    endfunction

    function automatic logic [2:0] imm_type(logic [6:0] op);
        case (op)
            OP_BRANCH:        return IMM_B;
            OP_STORE:         return IMM_S;
            OP_JAL:           return IMM_J;
            OP_LUI, OP_AUIPC: return IMM_U;
            default:          return IMM_I;
        endcase
    endfunction

endpackage

// File: rtl/multicycle_control_if.sv
// Decoded-instruction, flag, memory-handshake and datapath-control bundle
// between the control unit (master) and the datapath/memory (slave).
interface multicycle_control_if #(
    parameter int ALU_CTRL_W = 4
);
    logic [6:0]            op_i;
    logic [2:0]            funct3_i;
    logic                  funct7_i;
    logic                  zero_i;
    logic                  lt_i;
    logic                  ltu_i;
    logic                  mem_ready_i;
    logic                  mem_req_o;
    logic                  mem_we_o;
    logic                  adr_src_o;
    logic                  ir_write_o;
    logic                  pc_write_o;
    logic                  pc_src_o;
    logic                  reg_write_o;
    logic [ALU_CTRL_W-1:0] alu_ctrl_o;
    logic [1:0]            alu_src_a_o;
    logic [1:0]            alu_src_b_o;
    logic [2:0]            imm_src_o;
    logic [1:0]            result_src_o;
    logic                  illegal_o;
    logic                  fault_o;
    logic [3:0]            state_o;

    modport master (
        input  op_i, funct3_i, funct7_i, zero_i, lt_i, ltu_i, mem_ready_i,
        output mem_req_o, mem_we_o, adr_src_o, ir_write_o, pc_write_o, pc_src_o,
               reg_write_o, alu_ctrl_o, alu_src_a_o, alu_src_b_o, imm_src_o,
               result_src_o, illegal_o, fault_o, state_o
    );

    modport slave (
        output op_i, funct3_i, funct7_i, zero_i, lt_i, ltu_i, mem_ready_i,
        input  mem_req_o, mem_we_o, adr_src_o, ir_write_o, pc_write_o, pc_src_o,
               reg_write_o, alu_ctrl_o, alu_src_a_o, alu_src_b_o, imm_src_o,
               result_src_o, illegal_o, fault_o, state_o
    );
endinterface

// File: rtl/branch_cond.sv
// Branch resolution: maps funct3 and ALU compare flags to taken/illegal.
module branch_cond (
    input  logic [2:0] funct3_i,
    input  logic       zero_i,
    input  logic       lt_i,
    input  logic       ltu_i,
    output logic       taken_o,
    output logic       illegal_o
);
    always_comb begin
        // NOTE: every output gets a default before the case so no path leaves it unassigned (no latch).
        taken_o   = 1'b0;
        illegal_o = 1'b0;
        case (funct3_i)
            3'b000:  taken_o = zero_i;
            3'b001:  taken_o = !zero_i;
            3'b100:  taken_o = lt_i;
            3'b101:  taken_o = !lt_i;
            3'b110:  taken_o = ltu_i;
            3'b111:  taken_o = !ltu_i;
            default: illegal_o = 1'b1;
        endcase
    end
endmodule

// File: rtl/multicycle_control.sv
// Multicycle RV32I control FSM: sequences fetch/decode/execute/memory/writeback
// over a shared datapath with one req/ready memory port and a timeout trap.
module multicycle_control
    import ctrl_pkg::*;
#(
    parameter int ALU_CTRL_W  = 4,
    parameter int MEM_TIMEOUT = 16
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    multicycle_control_if.master bus
);
    localparam bit TIMEOUT_EN = (MEM_TIMEOUT > 0);
    localparam int CNT_W      = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'((MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0);

    state_e           state, state_next;
    logic [CNT_W-1:0] wait_cnt, wait_cnt_next;
    logic             illegal_q, fault_q;
    logic             set_illegal, set_fault;
    logic             br_taken, br_illegal, dec_illegal;
    logic             waiting, timeout_hit;

    alu_op_e    alu_op;
    logic       mem_req, mem_we, adr_src, ir_write, pc_write, pc_src, reg_write;
    logic [1:0] alu_src_a, alu_src_b, result_src;
    logic [2:0] imm_src;

    branch_cond u_branch_cond (
        .funct3_i  (bus.funct3_i),
        .zero_i    (bus.zero_i),
        .lt_i      (bus.lt_i),
        .ltu_i     (bus.ltu_i),
        .taken_o   (br_taken),
        .illegal_o (br_illegal)
    );

    // A wait cycle is one where an access is requested but not completed; the
    // last allowed wait cycle trips the trap unless ready arrives in it.
    assign waiting     = (state == FETCH || state == MEM) && !bus.mem_ready_i && !rst_i;
    assign timeout_hit = TIMEOUT_EN && waiting && (wait_cnt == CNT_LIMIT);

    always_comb begin
        wait_cnt_next = '0;
        if (TIMEOUT_EN && waiting && !timeout_hit)
            wait_cnt_next = wait_cnt + CNT_W'(1);
    end

    // For non-shift I-ALU ops bit 30 is immediate data, so it is not checked there.
    always_comb begin
        dec_illegal = 1'b0;
        case (bus.op_i)
            OP_R:      dec_illegal = bus.funct7_i && !(bus.funct3_i == 3'b000 || bus.funct3_i == 3'b101);
            OP_IMM:    dec_illegal = bus.funct7_i && (bus.funct3_i == 3'b001);
            OP_LOAD:   dec_illegal = (bus.funct3_i == 3'b011) || (bus.funct3_i[2:1] == 2'b11);
            OP_STORE:  dec_illegal = bus.funct3_i[2] || (bus.funct3_i == 3'b011);
            OP_BRANCH: dec_illegal = br_illegal;
            OP_JALR:   dec_illegal = (bus.funct3_i != 3'b000);
            OP_JAL, OP_LUI, OP_AUIPC: dec_illegal = 1'b0;
            default:   dec_illegal = 1'b1;
        endcase
    end

    always_comb begin
        state_next  = state;
        set_illegal = 1'b0;
        set_fault   = 1'b0;
        mem_req     = 1'b0;
        mem_we      = 1'b0;
        adr_src     = ADR_PC;
        ir_write    = 1'b0;
        pc_write    = 1'b0;
        pc_src      = PC_ALU;
        reg_write   = 1'b0;
        alu_op      = ALU_ADD;
        alu_src_a   = SRC_A_PC;
        alu_src_b   = SRC_B_RS2;
        imm_src     = IMM_I;
        result_src  = RES_ALUOUT;

        case (state)
            FETCH: begin
                mem_req   = 1'b1;
                alu_src_b = SRC_B_FOUR;
                if (timeout_hit) begin
                    mem_req    = 1'b0;
                    set_fault  = 1'b1;
                    state_next = TRAP;
                end else if (bus.mem_ready_i) begin
                    ir_write   = 1'b1;
                    pc_write   = 1'b1;
                    state_next = DECODE;
                end
            end

            DECODE: begin
                alu_src_a = SRC_A_OLDPC;
                alu_src_b = SRC_B_IMM;
                imm_src   = imm_type(bus.op_i);
                if (dec_illegal) begin
                    set_illegal = 1'b1;
                    state_next  = TRAP;
                end else begin
                    state_next = EXECUTE;
                end
            end

            EXECUTE: begin
                case (bus.op_i)
                    OP_R: begin
                        alu_src_a  = SRC_A_RS1;
                        alu_op     = alu_decode(bus.funct3_i, bus.funct7_i, 1'b1);
                        state_next = WB;
                    end
                    OP_IMM: begin
                        alu_src_a  = SRC_A_RS1;
                        alu_src_b  = SRC_B_IMM;
                        alu_op     = alu_decode(bus.funct3_i, bus.funct7_i, 1'b0);
                        state_next = WB;
                    end
                    OP_LUI: begin
                        alu_src_b  = SRC_B_IMM;
                        imm_src    = IMM_U;
                        alu_op     = ALU_PASSB;
                        state_next = WB;
                    end
                    OP_AUIPC: begin
                        alu_src_a  = SRC_A_OLDPC;
                        alu_src_b  = SRC_B_IMM;
                        imm_src    = IMM_U;
                        state_next = WB;
                    end
                    OP_LOAD, OP_STORE: begin
                        alu_src_a  = SRC_A_RS1;
                        alu_src_b  = SRC_B_IMM;
                        imm_src    = (bus.op_i == OP_STORE) ? IMM_S : IMM_I;
                        state_next = MEM;
                    end
                    OP_BRANCH: begin
                        alu_src_a  = SRC_A_RS1;
                        alu_op     = ALU_SUB;
                        pc_src     = PC_ALUOUT;
                        pc_write   = br_taken;
                        state_next = FETCH;
                    end
                    OP_JAL: begin
                        alu_src_a  = SRC_A_OLDPC;
                        alu_src_b  = SRC_B_FOUR;
                        result_src = RES_ALU;
                        reg_write  = 1'b1;
                        pc_src     = PC_ALUOUT;
                        pc_write   = 1'b1;
                        state_next = FETCH;
                    end
                    OP_JALR: begin
                        alu_src_a  = SRC_A_RS1;
                        alu_src_b  = SRC_B_IMM;
                        state_next = JUMP;
                    end
                    default: begin
                        set_illegal = 1'b1;
                        state_next  = TRAP;
                    end
                endcase
            end

            JUMP: begin
                alu_src_a  = SRC_A_OLDPC;
                alu_src_b  = SRC_B_FOUR;
                result_src = RES_ALU;
                reg_write  = 1'b1;
                pc_src     = PC_ALUOUT;
                pc_write   = 1'b1;
                state_next = FETCH;
            end

            MEM: begin
                mem_req = 1'b1;
                adr_src = ADR_ALUOUT;
                mem_we  = (bus.op_i == OP_STORE);
                if (timeout_hit) begin
                    mem_req    = 1'b0;
                    mem_we     = 1'b0;
                    set_fault  = 1'b1;
                    state_next = TRAP;
                end else if (bus.mem_ready_i) begin
                    state_next = (bus.op_i == OP_STORE) ? FETCH : WB;
                end
            end

            WB: begin
                reg_write  = 1'b1;
                result_src = (bus.op_i == OP_LOAD) ? RES_MEM : RES_ALUOUT;
                state_next = FETCH;
            end

            TRAP: state_next = TRAP;

            default: state_next = FETCH;
        endcase

        // Reset abandons any in-flight access without a write.
        if (rst_i) begin
            mem_req     = 1'b0;
            mem_we      = 1'b0;
            ir_write    = 1'b0;
            pc_write    = 1'b0;
            reg_write   = 1'b0;
            set_illegal = 1'b0;
            set_fault   = 1'b0;
            state_next  = FETCH;
        end
    end

    always_ff @(posedge clk_i) begin
        // NOTE: non-blocking assignments so every register samples pre-edge values.
        if (rst_i) begin
            state     <= FETCH;
            wait_cnt  <= '0;
            illegal_q <= 1'b0;
            fault_q   <= 1'b0;
        end else begin
            state    <= state_next;
            wait_cnt <= wait_cnt_next;
            if (set_illegal) illegal_q <= 1'b1;
            if (set_fault)   fault_q   <= 1'b1;
        end
    end

    assign bus.mem_req_o    = mem_req;
    assign bus.mem_we_o     = mem_we;
    assign bus.adr_src_o    = adr_src;
    assign bus.ir_write_o   = ir_write;
    assign bus.pc_write_o   = pc_write;
    assign bus.pc_src_o     = pc_src;
    assign bus.reg_write_o  = reg_write;
    assign bus.alu_ctrl_o   = ALU_CTRL_W'(alu_op);
    assign bus.alu_src_a_o  = alu_src_a;
    assign bus.alu_src_b_o  = alu_src_b;
    assign bus.imm_src_o    = imm_src;
    assign bus.result_src_o = result_src;
    assign bus.illegal_o    = illegal_q;
    assign bus.fault_o      = fault_q;
    assign bus.state_o      = state;

endmodule

// File: tb/tb_multicycle_control.sv
// Self-checking bench for multicycle_control: directed scenarios followed by
// random instructions compared cycle by cycle against a phase-list model.
module tb_multicycle_control;
  import ctrl_pkg::*;

  logic clk_i = 1'b0;
  logic rst_i = 1'b1;
  int   total = 0;
  int   bad   = 0;

  multicycle_control_if #(.ALU_CTRL_W(4)) bus ();

  multicycle_control #(.ALU_CTRL_W(4), .MEM_TIMEOUT(16)) dut (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .bus   (bus)
  );

  always #5 clk_i = ~clk_i;

  typedef enum {K_ALU_R, K_ALU_I, K_LUI, K_AUIPC, K_LOAD, K_STORE, K_BR, K_JAL, K_JALR, K_ILL} kind_e;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk_i);
    #1;
  endtask

  function automatic kind_e classify(logic [6:0] op, logic [2:0] f3, logic f7);
    case (op)
      7'b0110011: return (f7 && !(f3 == 3'd0 || f3 == 3'd5)) ? K_ILL : K_ALU_R;
      7'b0010011: return (f7 && f3 == 3'd1) ? K_ILL : K_ALU_I;
      7'b0000011: return (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5}) ? K_LOAD : K_ILL;
      7'b0100011: return (f3 <= 3'd2) ? K_STORE : K_ILL;
      7'b1100011: return (f3 inside {3'd2, 3'd3}) ? K_ILL : K_BR;
      7'b1101111: return K_JAL;
      7'b1100111: return (f3 == 3'd0) ? K_JALR : K_ILL;
      7'b0110111: return K_LUI;
      7'b0010111: return K_AUIPC;
      default:    return K_ILL;
    endcase
  endfunction

  function automatic bit is_taken(logic [2:0] f3, logic z, logic lt, logic ltu);
    case (f3)
      3'd0:    return z;
      3'd1:    return !z;
      3'd4:    return lt;
      3'd5:    return !lt;
      3'd6:    return ltu;
      default: return !ltu;
    endcase
  endfunction

  function automatic int exp_alu(kind_e k, logic [2:0] f3, logic f7);
    int base [8] = '{0, 7, 5, 6, 4, 8, 3, 2};
    int r = 0;
    case (k)
      K_ALU_R, K_ALU_I: begin
        r = base[f3];
        if (f7 && f3 == 3'd5) r = 9;
        if (k == K_ALU_R && f7 && f3 == 3'd0) r = 1;
      end
      K_LUI:   r = 10;
      K_BR:    r = 1;
      default: r = 0;
    endcase
    return r;
  endfunction

  function automatic int exp_src_b(kind_e k);
    case (k)
      K_ALU_R, K_BR: return 0;
      K_JAL:         return 2;
      default:       return 1;
    endcase
  endfunction

  task automatic do_reset();
    rst_i = 1'b1;
    bus.mem_ready_i = 1'b1;
    repeat (2) begin
      @(negedge clk_i);
      check("rst.mem_req", bus.mem_req_o, 0);
      check("rst.pc_write", bus.pc_write_o, 0);
      check("rst.reg_write", bus.reg_write_o, 0);
      cyc();
    end
    rst_i = 1'b0;
    bus.mem_ready_i = 1'b0;
  endtask

  // Runs one instruction from its first FETCH cycle; fw/mw are wait cycles per access.
  task automatic run_instr(input string name, input logic [6:0] op, input logic [2:0] f3,
                           input logic f7, input logic z, input logic lt, input logic ltu,
                           input int fw, input int mw);
    kind_e  k = classify(op, f3, f7);
    bit     tk = is_taken(f3, z, lt, ltu);
    state_e ph [$];
    int     fc = 0;
    int     mc = 0;
    logic   rdy;
    for (int i = 0; i <= fw; i++) ph.push_back(FETCH);
    ph.push_back(DECODE);
    case (k)
      K_ALU_R, K_ALU_I, K_LUI, K_AUIPC: begin ph.push_back(EXECUTE); ph.push_back(WB); end
      K_LOAD: begin
        ph.push_back(EXECUTE);
        for (int i = 0; i <= mw; i++) ph.push_back(MEM);
        ph.push_back(WB);
      end
      K_STORE: begin
        ph.push_back(EXECUTE);
        for (int i = 0; i <= mw; i++) ph.push_back(MEM);
      end
      K_BR, K_JAL: ph.push_back(EXECUTE);
      K_JALR: begin ph.push_back(EXECUTE); ph.push_back(JUMP); end
      default: ;
    endcase

    bus.op_i = op; bus.funct3_i = f3; bus.funct7_i = f7;
    bus.zero_i = z; bus.lt_i = lt; bus.ltu_i = ltu;

    foreach (ph[i]) begin
      rdy = 1'b0;
      if (ph[i] == FETCH) begin rdy = (fc == fw); fc++; end
      if (ph[i] == MEM)   begin rdy = (mc == mw); mc++; end
      bus.mem_ready_i = rdy;
      @(negedge clk_i);
      if (i == 0) begin
        check({name, ".illegal_clear"}, bus.illegal_o, 0);
        check({name, ".fault_clear"}, bus.fault_o, 0);
      end
      check({name, ".state"}, bus.state_o, ph[i]);
      check({name, ".mem_req"}, bus.mem_req_o, ph[i] == FETCH || ph[i] == MEM);
      check({name, ".mem_we"}, bus.mem_we_o, ph[i] == MEM && k == K_STORE);
      check({name, ".ir_write"}, bus.ir_write_o, ph[i] == FETCH && rdy);
      check({name, ".reg_write"}, bus.reg_write_o,
            ph[i] == WB || ph[i] == JUMP || (ph[i] == EXECUTE && k == K_JAL));
      check({name, ".pc_write"}, bus.pc_write_o,
            (ph[i] == FETCH && rdy) || ph[i] == JUMP ||
            (ph[i] == EXECUTE && (k == K_JAL || (k == K_BR && tk))));
      if (ph[i] == EXECUTE) begin
        check({name, ".alu_ctrl"}, bus.alu_ctrl_o, exp_alu(k, f3, f7));
        check({name, ".alu_src_b"}, bus.alu_src_b_o, exp_src_b(k));
      end
      if (ph[i] == MEM) check({name, ".adr_src"}, bus.adr_src_o, 1);
      if (ph[i] == WB)  check({name, ".result_src"}, bus.result_src_o, k == K_LOAD);
      cyc();
    end
    bus.mem_ready_i = 1'b0;

    if (k == K_ILL) begin
      repeat (3) begin
        @(negedge clk_i);
        check({name, ".trap_state"}, bus.state_o, TRAP);
        check({name, ".trap_illegal"}, bus.illegal_o, 1);
        check({name, ".trap_req"}, bus.mem_req_o, 0);
        check({name, ".trap_reg_write"}, bus.reg_write_o, 0);
        cyc();
      end
      do_reset();
    end
  endtask

  initial begin
    logic [6:0] ops [11] = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011, 7'b1100011,
                             7'b1101111, 7'b1100111, 7'b0110111, 7'b0010111, 7'b0000000,
                             7'b1111111};
    bus.op_i = '0; bus.funct3_i = '0; bus.funct7_i = 1'b0;
    bus.zero_i = 1'b0; bus.lt_i = 1'b0; bus.ltu_i = 1'b0; bus.mem_ready_i = 1'b0;
    do_reset();

    run_instr("addi", 7'b0010011, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0);
    run_instr("bne_taken", 7'b1100011, 3'd1, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0);
    run_instr("bne_not", 7'b1100011, 3'd1, 1'b0, 1'b1, 1'b0, 1'b0, 0, 0);
    run_instr("lw_wait3", 7'b0000011, 3'd2, 1'b0, 1'b0, 1'b0, 1'b0, 0, 3);
    run_instr("sra", 7'b0110011, 3'd5, 1'b1, 1'b0, 1'b0, 1'b0, 0, 0);
    run_instr("sub", 7'b0110011, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 0, 0);
    run_instr("op0", 7'b0000000, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0);
    run_instr("jal", 7'b1101111, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0);

    // Ready on the 16th fetch cycle completes the access without a fault.
    run_instr("fetch_ready16", 7'b0010011, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 15, 0);

    // Ready never arrives: the 16th wait cycle drops the request and traps.
    bus.op_i = 7'b0010011; bus.funct3_i = 3'd0; bus.mem_ready_i = 1'b0;
    for (int c = 1; c <= 16; c++) begin
      @(negedge clk_i);
      check("timeout.state", bus.state_o, FETCH);
      check("timeout.mem_req", bus.mem_req_o, c < 16);
      check("timeout.ir_write", bus.ir_write_o, 0);
      cyc();
    end
    repeat (2) begin
      @(negedge clk_i);
      check("timeout.trap_state", bus.state_o, TRAP);
      check("timeout.fault", bus.fault_o, 1);
      check("timeout.illegal", bus.illegal_o, 0);
      check("timeout.trap_req", bus.mem_req_o, 0);
      cyc();
    end
    do_reset();

    // Reset pulsed in MEM of a store abandons the access.
    bus.op_i = 7'b0100011; bus.funct3_i = 3'd2; bus.funct7_i = 1'b0;
    bus.mem_ready_i = 1'b1;
    @(negedge clk_i); check("rst_st.fetch", bus.state_o, FETCH); cyc();
    bus.mem_ready_i = 1'b0;
    @(negedge clk_i); check("rst_st.decode", bus.state_o, DECODE); cyc();
    @(negedge clk_i); check("rst_st.execute", bus.state_o, EXECUTE); cyc();
    @(negedge clk_i);
    check("rst_st.mem", bus.state_o, MEM);
    check("rst_st.mem_we", bus.mem_we_o, 1);
    cyc();
    rst_i = 1'b1; bus.mem_ready_i = 1'b1;
    @(negedge clk_i);
    check("rst_st.pulse_we", bus.mem_we_o, 0);
    check("rst_st.pulse_req", bus.mem_req_o, 0);
    check("rst_st.pulse_reg_write", bus.reg_write_o, 0);
    cyc();
    rst_i = 1'b0; bus.mem_ready_i = 1'b0;
    @(negedge clk_i);
    check("rst_st.after_state", bus.state_o, FETCH);
    check("rst_st.after_we", bus.mem_we_o, 0);
    check("rst_st.after_reg_write", bus.reg_write_o, 0);
    cyc();

    for (int n = 0; n < 150; n++) begin
      run_instr("rand", ops[$urandom_range(0, 10)], 3'($urandom_range(0, 7)),
                1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                $urandom_range(0, 4), $urandom_range(0, 4));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
